wb_classic_regfile: RTL and testbench



---
 rtl/wb_pkg.sv | 22 ++
 rtl/wb_byte_reg.sv | 39 +++
 rtl/wb_classic_regfile.sv | 166 ++++++++++++++++
 tb/tb_wb_classic_regfile.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
//------------------------------------------------------------------------------
// Module  : wb_pkg
// Brief   : Shared Wishbone classic device types and helpers.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package wb_pkg;

  typedef enum logic [1:0] {NONE, ACK, ERR, RTY} wb_term_t;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} wb_state_t;

  localparam int WS_WIDTH = 4;

  function automatic int sel_width(input int dat_width);
    return dat_width / 8;
  endfunction

endpackage

`default_nettype wire

// File: rtl/wb_byte_reg.sv
//------------------------------------------------------------------------------
// Module  : wb_byte_reg
// Brief   : One data word with per-byte-lane write enables.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module wb_byte_reg
  import wb_pkg::*;
#(
  parameter int                   DAT_WIDTH   = 32,
  parameter logic [DAT_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [DAT_WIDTH/8-1:0] lane_we_i,
  input  logic [DAT_WIDTH-1:0]   dat_i,
  output logic [DAT_WIDTH-1:0]   q_o
);

  localparam int SEL_WIDTH = sel_width(DAT_WIDTH);

  logic [DAT_WIDTH-1:0] r_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_q <= RESET_VALUE;
    end else begin
      for (int b = 0; b < SEL_WIDTH; b++) begin
        if (lane_we_i[b]) r_q[b*8 +: 8] <= dat_i[b*8 +: 8];
      end
    end
  end

  assign q_o = r_q;

endmodule

`default_nettype wire

// File: rtl/wb_classic_regfile.sv
//------------------------------------------------------------------------------
// Module  : wb_classic_regfile
// Brief   : Wishbone B4 classic register bank with wait states and ack/err/rty.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module wb_classic_regfile
  import wb_pkg::*;
#(
  parameter int                   DAT_WIDTH   = 32,
  parameter int                   NUM_REGS    = 16,
  parameter int                   ADR_WIDTH   = 4,
  parameter int                   WAIT_STATES = 1,
  parameter logic [DAT_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          cyc_i,
  input  logic                          stb_i,
  input  logic                          we_i,
  input  logic [ADR_WIDTH-1:0]          adr_i,
  input  logic [DAT_WIDTH/8-1:0]        sel_i,
  input  logic [DAT_WIDTH-1:0]          dat_i,
  input  logic                          lock_i,
  output logic [DAT_WIDTH-1:0]          dat_o,
  output logic                          ack_o,
  output logic                          err_o,
  output logic                          rty_o,
  output logic [NUM_REGS*DAT_WIDTH-1:0] regs_o
);

  localparam int                  SEL_WIDTH     = sel_width(DAT_WIDTH);
  localparam logic [WS_WIDTH-1:0] c_wait_states = WS_WIDTH'(WAIT_STATES);

  wb_state_t             r_state, w_state_nxt;
  logic [WS_WIDTH-1:0]   r_cnt, w_cnt_nxt;
  wb_term_t              w_term;
  logic                  w_req, w_enter_resp, w_in_range, w_commit;
  logic [NUM_REGS-1:0]   w_adr_hit;
  logic [DAT_WIDTH-1:0]  w_rd_word, w_mask;
  logic [DAT_WIDTH-1:0]  w_regs [NUM_REGS];
  logic [SEL_WIDTH-1:0]  w_lane_we [NUM_REGS];
  logic [DAT_WIDTH-1:0]  r_dat;
  logic                  r_ack, r_err, r_rty;

  assign w_req      = cyc_i && stb_i;
  assign w_in_range = (32'(adr_i) < 32'(NUM_REGS));
  assign w_commit   = (w_term == ACK) && we_i;

  always_comb begin
    w_rd_word = '0;
    w_mask    = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      w_adr_hit[k] = (adr_i == ADR_WIDTH'(k));
      if (w_adr_hit[k]) w_rd_word = w_regs[k];
    end
    for (int b = 0; b < SEL_WIDTH; b++) begin
      w_mask[b*8 +: 8] = {8{sel_i[b]}};
    end
  end

  // Termination is decided on the edge that enters RESP, from the live bus fields.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_enter_resp = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_req) begin
          if (WAIT_STATES == 0) begin
            w_state_nxt  = RESP;
            w_enter_resp = 1'b1;
          end else begin
            w_state_nxt = WAIT;
            w_cnt_nxt   = c_wait_states;
          end
        end
      end
      WAIT: begin
        if (!w_req) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt <= WS_WIDTH'(1)) begin
          w_state_nxt  = RESP;
          w_enter_resp = 1'b1;
          w_cnt_nxt    = '0;
        end else begin
          w_cnt_nxt = r_cnt - WS_WIDTH'(1);
        end
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase

    w_term = NONE;
    if (w_enter_resp) begin
      if (!w_in_range)        w_term = ERR;
      else if (we_i && lock_i) w_term = RTY;
      else                    w_term = ACK;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_rty   <= 1'b0;
      r_dat   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ack   <= (w_term == ACK);
      r_err   <= (w_term == ERR);
      r_rty   <= (w_term == RTY);
      r_dat   <= ((w_term == ACK) && !we_i) ? (w_rd_word & w_mask) : '0;
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg
    assign w_lane_we[k] = {SEL_WIDTH{w_commit && w_adr_hit[k]}} & sel_i;

    wb_byte_reg #(
      .DAT_WIDTH   (DAT_WIDTH),
      .RESET_VALUE (RESET_VALUE)
    ) u_reg (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .lane_we_i (w_lane_we[k]),
      .dat_i     (dat_i),
      .q_o       (w_regs[k])
    );

    assign regs_o[k*DAT_WIDTH +: DAT_WIDTH] = w_regs[k];
  end

  assign dat_o = r_dat;
  assign ack_o = r_ack;
  assign err_o = r_err;
  assign rty_o = r_rty;

`ifdef FORMAL
  // The controller holds the request fields stable while the device is waiting.
  asm_stable: assume property (@(posedge clk_i) disable iff (!rst_ni)
    (r_state == WAIT && w_req) |-> $stable({we_i, adr_i, sel_i, dat_i}));

  ast_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0({ack_o, err_o, rty_o}));

  ast_no_ack_no_change: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !ack_o |-> $stable(regs_o));

  if (WAIT_STATES == 0) begin : g_lat_zero
    ast_latency: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (r_state == IDLE && w_req) |=> (ack_o || err_o || rty_o));
  end else begin : g_lat_wait
    ast_latency: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (r_state == IDLE && w_req) ##1 w_req [*WAIT_STATES] |=> (ack_o || err_o || rty_o));
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_wb_classic_regfile.sv
//------------------------------------------------------------------------------
// Module  : tb_wb_classic_regfile
// Brief   : Directed bench for three regfile configurations (1, 4 and 0 wait states).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_wb_classic_regfile;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         we;
  logic [4:0]   adr;
  logic [3:0]   sel;
  logic [31:0]  dat;
  logic         lock;

  logic         cyc_a, stb_a, cyc_b, stb_b, cyc_c, stb_c;
  logic [31:0]  dat_a, dat_b, dat_c;
  logic         ack_a, err_a, rty_a, ack_b, err_b, rty_b, ack_c, err_c, rty_c;
  logic [511:0] regs_a, regs_b, regs_c;
  logic [511:0] exp_a, exp_b, exp_c;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  wb_classic_regfile #(.DAT_WIDTH(32), .NUM_REGS(16), .ADR_WIDTH(5), .WAIT_STATES(1),
                       .RESET_VALUE(32'h0000_0000)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .cyc_i(cyc_a), .stb_i(stb_a), .we_i(we), .adr_i(adr),
    .sel_i(sel), .dat_i(dat), .lock_i(lock), .dat_o(dat_a), .ack_o(ack_a), .err_o(err_a),
    .rty_o(rty_a), .regs_o(regs_a));

  wb_classic_regfile #(.DAT_WIDTH(32), .NUM_REGS(16), .ADR_WIDTH(5), .WAIT_STATES(4),
                       .RESET_VALUE(32'h5A5A_5A5A)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .cyc_i(cyc_b), .stb_i(stb_b), .we_i(we), .adr_i(adr),
    .sel_i(sel), .dat_i(dat), .lock_i(lock), .dat_o(dat_b), .ack_o(ack_b), .err_o(err_b),
    .rty_o(rty_b), .regs_o(regs_b));

  wb_classic_regfile #(.DAT_WIDTH(32), .NUM_REGS(16), .ADR_WIDTH(5), .WAIT_STATES(0),
                       .RESET_VALUE(32'h0000_0000)) u_dut_c (
    .clk_i(clk), .rst_ni(rst_n), .cyc_i(cyc_c), .stb_i(stb_c), .we_i(we), .adr_i(adr),
    .sel_i(sel), .dat_i(dat), .lock_i(lock), .dat_o(dat_c), .ack_o(ack_c), .err_o(err_c),
    .rty_o(rty_c), .regs_o(regs_c));

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] term_of(input int which);
    case (which)
      0:       return {ack_a, err_a, rty_a};
      1:       return {ack_b, err_b, rty_b};
      default: return {ack_c, err_c, rty_c};
    endcase
  endfunction

  function automatic logic [31:0] dat_of(input int which);
    case (which)
      0:       return dat_a;
      1:       return dat_b;
      default: return dat_c;
    endcase
  endfunction

  task automatic set_req(input int which, input logic v);
    case (which)
      0:       begin cyc_a = v; stb_a = v; end
      1:       begin cyc_b = v; stb_b = v; end
      default: begin cyc_c = v; stb_c = v; end
    endcase
  endtask

  task automatic start(input int which, input logic w, input logic [4:0] a,
                       input logic [3:0] s, input logic [31:0] d);
    @(posedge clk); #1;
    we = w; adr = a; sel = s; dat = d;
    set_req(which, 1'b1);
  endtask

  // Bounded wait: lat reaches budget with t == 0 if no termination shows up.
  task automatic wait_term(input int which, input int budget, output int lat, output logic [2:0] t);
    lat = 0;
    t   = 3'b000;
    while (t == 3'b000 && lat < budget) begin
      @(posedge clk); #1;
      lat++;
      t = term_of(which);
    end
  endtask

  task automatic xfer(input int which, input logic w, input logic [4:0] a, input logic [3:0] s,
                      input logic [31:0] d, output int lat, output logic [2:0] t,
                      output logic [31:0] rd);
    start(which, w, a, s, d);
    wait_term(which, 20, lat, t);
    rd = dat_of(which);
    set_req(which, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, lat2;
    logic [2:0]  t, t2;
    logic [31:0] rd;

    rst_n = 1'b0; we = 1'b0; adr = '0; sel = '0; dat = '0; lock = 1'b0;
    cyc_a = 1'b0; stb_a = 1'b0; cyc_b = 1'b0; stb_b = 1'b0; cyc_c = 1'b0; stb_c = 1'b0;
    exp_a = '0; exp_b = {16{32'h5A5A_5A5A}}; exp_c = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("rst_term_a", 512'(term_of(0)), 512'(3'b000));
    chk("rst_dat_a", 512'(dat_a), 512'(32'h0));
    chk("rst_regs_a", regs_a, exp_a);
    chk("rst_regs_b", regs_b, exp_b);

    // Full-word write then read on the 1-wait-state device.
    xfer(0, 1'b1, 5'd3, 4'hF, 32'hDEAD_BEEF, lat, t, rd);
    exp_a[3*32 +: 32] = 32'hDEAD_BEEF;
    chk("wr3_lat", 512'(lat), 512'(2));
    chk("wr3_term", 512'(t), 512'(3'b100));
    chk("wr3_regs", regs_a, exp_a);
    xfer(0, 1'b0, 5'd3, 4'hF, 32'h0, lat, t, rd);
    chk("rd3_lat", 512'(lat), 512'(2));
    chk("rd3_term", 512'(t), 512'(3'b100));
    chk("rd3_dat", 512'(rd), 512'(32'hDEAD_BEEF));
    @(posedge clk); #1;
    chk("post_ack_term", 512'(term_of(0)), 512'(3'b000));
    chk("post_ack_dat", 512'(dat_a), 512'(32'h0));

    // Byte lanes.
    xfer(0, 1'b1, 5'd5, 4'hF, 32'h1122_3344, lat, t, rd);
    xfer(0, 1'b1, 5'd5, 4'h5, 32'hAABB_CCDD, lat, t, rd);
    exp_a[5*32 +: 32] = 32'h11BB_33DD;
    chk("lane_wr_term", 512'(t), 512'(3'b100));
    chk("lane_wr_regs", regs_a, exp_a);
    xfer(0, 1'b0, 5'd5, 4'h2, 32'h0, lat, t, rd);
    chk("lane_rd_dat", 512'(rd), 512'(32'h0000_3300));
    xfer(0, 1'b1, 5'd3, 4'h0, 32'hFFFF_FFFF, lat, t, rd);
    chk("sel0_term", 512'(t), 512'(3'b100));
    chk("sel0_regs", regs_a, exp_a);

    // Out-of-range address.
    xfer(0, 1'b1, 5'd20, 4'hF, 32'hCAFE_F00D, lat, t, rd);
    chk("oor_wr_term", 512'(t), 512'(3'b010));
    chk("oor_wr_lat", 512'(lat), 512'(2));
    chk("oor_wr_regs", regs_a, exp_a);
    xfer(0, 1'b0, 5'd20, 4'hF, 32'h0, lat, t, rd);
    chk("oor_rd_term", 512'(t), 512'(3'b010));
    chk("oor_rd_dat", 512'(rd), 512'(32'h0));

    // Lock: writes retry, reads unaffected, unlocked retry commits.
    lock = 1'b1;
    xfer(0, 1'b1, 5'd0, 4'hF, 32'h0BAD_CAFE, lat, t, rd);
    chk("lock_wr_term", 512'(t), 512'(3'b001));
    chk("lock_wr_regs", regs_a, exp_a);
    xfer(0, 1'b0, 5'd0, 4'hF, 32'h0, lat, t, rd);
    chk("lock_rd_term", 512'(t), 512'(3'b100));
    chk("lock_rd_dat", 512'(rd), 512'(32'h0));
    lock = 1'b0;
    xfer(0, 1'b1, 5'd0, 4'hF, 32'h0BAD_CAFE, lat, t, rd);
    exp_a[0*32 +: 32] = 32'h0BAD_CAFE;
    chk("unlock_wr_term", 512'(t), 512'(3'b100));
    chk("unlock_wr_regs", regs_a, exp_a);

    // Abort on the single wait cycle of device A.
    start(0, 1'b1, 5'd7, 4'hF, 32'h1234_5678);
    @(posedge clk); #1;
    cyc_a = 1'b0;
    wait_term(0, 6, lat, t);
    stb_a = 1'b0;
    chk("abort_a_term", 512'(t), 512'(3'b000));
    chk("abort_a_regs", regs_a, exp_a);

    // Four wait states: latency and partial write onto a non-zero reset value.
    xfer(1, 1'b1, 5'd1, 4'h3, 32'h0000_BEEF, lat, t, rd);
    exp_b[1*32 +: 32] = 32'h5A5A_BEEF;
    chk("ws4_lat", 512'(lat), 512'(5));
    chk("ws4_term", 512'(t), 512'(3'b100));
    chk("ws4_regs", regs_b, exp_b);

    // Abort on wait cycle 2 of device B.
    start(1, 1'b1, 5'd2, 4'hF, 32'h7777_7777);
    @(posedge clk); #1;
    @(posedge clk); #1;
    cyc_b = 1'b0;
    wait_term(1, 8, lat, t);
    stb_b = 1'b0;
    chk("abort_b_term", 512'(t), 512'(3'b000));
    chk("abort_b_regs", regs_b, exp_b);

    // Zero wait states, request held across two writes.
    start(2, 1'b1, 5'd1, 4'hF, 32'h1111_1111);
    wait_term(2, 5, lat, t);
    adr = 5'd2; dat = 32'h2222_2222;
    wait_term(2, 5, lat2, t2);
    set_req(2, 1'b0);
    exp_c[1*32 +: 32] = 32'h1111_1111;
    exp_c[2*32 +: 32] = 32'h2222_2222;
    chk("b2b_lat1", 512'(lat), 512'(1));
    chk("b2b_term1", 512'(t), 512'(3'b100));
    chk("b2b_lat2", 512'(lat2), 512'(2));
    chk("b2b_term2", 512'(t2), 512'(3'b100));
    chk("b2b_regs", regs_c, exp_c);

    // Asynchronous reset in the middle of a WAIT on device B.
    start(1, 1'b1, 5'd3, 4'hF, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    exp_a = '0; exp_b = {16{32'h5A5A_5A5A}}; exp_c = '0;
    chk("arst_term_b", 512'(term_of(1)), 512'(3'b000));
    chk("arst_dat_b", 512'(dat_b), 512'(32'h0));
    chk("arst_regs_a", regs_a, exp_a);
    chk("arst_regs_b", regs_b, exp_b);
    chk("arst_regs_c", regs_c, exp_c);
    set_req(1, 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;
    wait_term(1, 8, lat, t);
    chk("arst_no_term", 512'(t), 512'(3'b000));
    chk("arst_regs_b_after", regs_b, exp_b);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
